// File: rtl/udp_sample_framer.sv
// udp_sample_framer
// Packs a stream of 32-bit IQ samples into Ethernet/IPv4/UDP frames.
// Each frame has a 42-byte header, then a 32-bit sequence number, then
// PAYLOAD_SAMPLES samples. Frames carry no preamble or FCS; the MAC adds
// those. Bytes are written one at a time into the MAC transmit FIFO.
//
// Ports
//   tx_clk        : sole clock, shared with the MAC write side
//   rstn          : asynchronous active-low reset
//   enable        : starts a frame when sampled high while idle
//   sample_data   : {I[15:0], Q[15:0]}
//   sample_valid  : sample_data is present
//   sample_rdy    : sample is taken when sample_valid & sample_rdy
//   tx_data       : byte to the MAC
//   tx_sop/tx_eop : first/last byte of a frame
//   tx_err        : always 0
//   tx_wren       : tx_data is valid
//   tx_rdy        : MAC accepts; a byte moves when tx_wren & tx_rdy
//   seq           : sequence number of the next or current frame
//   busy          : a frame is being built
module udp_sample_framer #(
    parameter logic [47:0] SRC_MAC         = 48'h020000000001,
    parameter logic [47:0] DST_MAC         = 48'hFFFFFFFFFFFF,
    parameter logic [31:0] SRC_IP          = 32'hC0A80164,
    parameter logic [31:0] DST_IP          = 32'hC0A80101,
    parameter logic [15:0] SRC_PORT        = 16'd5000,
    parameter logic [15:0] DST_PORT        = 16'd5001,
    parameter logic [7:0]  TTL             = 8'd64,
    parameter int          PAYLOAD_SAMPLES = 256
) (
    input  logic        tx_clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic [31:0] sample_data,
    input  logic        sample_valid,
    output logic        sample_rdy,
    output logic [7:0]  tx_data,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic        tx_err,
    output logic        tx_wren,
    input  logic        tx_rdy,
    output logic [31:0] seq,
    output logic        busy
);

    localparam int          UDP_LEN_I     = 12 + 4 * PAYLOAD_SAMPLES;
    localparam logic [15:0] UDP_LEN       = 16'(UDP_LEN_I);
    localparam logic [15:0] IP_LEN        = 16'(UDP_LEN_I + 20);
    localparam logic [9:0]  LAST_SAMPLE   = 10'(PAYLOAD_SAMPLES);
    localparam logic [10:0] LAST_HDR_BYTE = 11'd45;

    typedef enum logic [2:0] {
        IDLE,
        CSUM_SUM,
        CSUM_FOLD,
        HEADER,
        PAYLOAD
    } state_t;

    state_t      state_q;
    logic [10:0] byteIdx_q;
    logic [1:0]  phase_q;
    logic        holdFull_q;
    logic [31:0] hold_q;
    logic [9:0]  loaded_q;
    logic [31:0] seq_q;
    logic [31:0] sum_q;
    logic [15:0] csum_q;

    logic [367:0] header;
    logic [5:0]   revIdx;
    logic [8:0]   bitPos;
    logic [7:0]   hdrByte;
    logic [7:0]   payByte;
    logic         xfer;
    logic         lastByte;
    logic         loadSample;
    logic [16:0]  fold1;
    logic [15:0]  fold2;

    // Output decode from registered state. The header is one big-endian
    // vector, and the byte index picks one byte from it. The holding register
    // may reload in the same cycle as its last byte goes out, so a steady
    // source keeps the MAC fed with no bubble.
    always_comb begin
        header = {DST_MAC, SRC_MAC, 16'h0800,
                  16'h4500, IP_LEN, seq_q[15:0], 16'h4000, TTL, 8'h11, csum_q,
                  SRC_IP, DST_IP,
                  SRC_PORT, DST_PORT, UDP_LEN, 16'h0000,
                  seq_q};
        revIdx  = 6'd45 - byteIdx_q[5:0];
        bitPos  = {revIdx, 3'b000};
        hdrByte = header[bitPos +: 8];

        case (phase_q)
            2'd0:    payByte = hold_q[31:24];
            2'd1:    payByte = hold_q[23:16];
            2'd2:    payByte = hold_q[15:8];
            default: payByte = hold_q[7:0];
        endcase

        tx_wren = (state_q == HEADER) || (state_q == PAYLOAD && holdFull_q);
        tx_data = 8'h00;
        if (state_q == HEADER) begin
            tx_data = hdrByte;
        end else if (state_q == PAYLOAD && holdFull_q) begin
            tx_data = payByte;
        end

        tx_sop     = (state_q == HEADER) && (byteIdx_q == 11'd0);
        lastByte   = (state_q == PAYLOAD) && holdFull_q && (phase_q == 2'd3) &&
                     (loaded_q == LAST_SAMPLE);
        tx_eop     = lastByte;
        xfer       = tx_wren && tx_rdy;
        sample_rdy = (state_q == PAYLOAD) && (loaded_q < LAST_SAMPLE) &&
                     (!holdFull_q || (phase_q == 2'd3 && tx_rdy));
        loadSample = sample_rdy && sample_valid;

        // The sum of ten 16-bit words fits in 20 bits, so two folds always
        // absorb every carry.
        fold1 = {1'b0, sum_q[31:16]} + {1'b0, sum_q[15:0]};
        fold2 = fold1[15:0] + {15'd0, fold1[16]};

        tx_err = 1'b0;
        busy   = (state_q != IDLE);
        seq    = seq_q;
    end

    // Frame sequencer. It computes the IPv4 checksum first, then steps
    // through the header bytes, then streams the payload from the holding
    // register. Any stall from the MAC freezes the index and the phase.
    always_ff @(posedge tx_clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            byteIdx_q  <= 11'd0;
            phase_q    <= 2'd0;
            holdFull_q <= 1'b0;
            hold_q     <= 32'd0;
            loaded_q   <= 10'd0;
            seq_q      <= 32'd0;
            sum_q      <= 32'd0;
            csum_q     <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= CSUM_SUM;
                    end
                end
                CSUM_SUM: begin
                    sum_q <= 32'h4500 + {16'd0, IP_LEN} + {16'd0, seq_q[15:0]} +
                             32'h4000 + {16'd0, TTL, 8'h11} +
                             {16'd0, SRC_IP[31:16]} + {16'd0, SRC_IP[15:0]} +
                             {16'd0, DST_IP[31:16]} + {16'd0, DST_IP[15:0]};
                    state_q <= CSUM_FOLD;
                end
                CSUM_FOLD: begin
                    csum_q    <= ~fold2;
                    byteIdx_q <= 11'd0;
                    state_q   <= HEADER;
                end
                HEADER: begin
                    if (tx_rdy) begin
                        if (byteIdx_q == LAST_HDR_BYTE) begin
                            state_q    <= PAYLOAD;
                            phase_q    <= 2'd0;
                            loaded_q   <= 10'd0;
                            holdFull_q <= 1'b0;
                        end else begin
                            byteIdx_q <= byteIdx_q + 11'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        if (phase_q == 2'd3) begin
                            phase_q <= 2'd0;
                            if (lastByte) begin
                                state_q    <= IDLE;
                                seq_q      <= seq_q + 32'd1;
                                holdFull_q <= 1'b0;
                            end else if (!loadSample) begin
                                holdFull_q <= 1'b0;
                            end
                        end else begin
                            phase_q <= phase_q + 2'd1;
                        end
                    end
                    if (loadSample) begin
                        hold_q     <= sample_data;
                        holdFull_q <= 1'b1;
                        loaded_q   <= loaded_q + 10'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_sample_framer.sv
// tb_udp_sample_framer
// Random-stimulus bench for udp_sample_framer. It drives two instances: one
// with the default 256-sample payload and one with a 1-sample payload.
// Only one instance is enabled at a time, and shared observation wires
// follow whichever one is selected. Expected frames come from a reference
// model. The model builds each frame from the header field layout, a plain
// ones-complement checksum and the samples the source actually handed over.
module tb_udp_sample_framer;

    localparam int N_A = 256;
    localparam int N_B = 1;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        sv;
    logic        rdy;
    logic        sel;
    logic [31:0] sd;

    logic        enA, enB;
    logic        srA, srB, sopA, sopB, eopA, eopB, errA, errB;
    logic        wrenA, wrenB, busyA, busyB;
    logic [7:0]  dataA, dataB;
    logic [31:0] seqA, seqB;

    logic        oSrdy, oSop, oEop, oErr, oWren, oBusy;
    logic [7:0]  oData;
    logic [31:0] oSeq;

    always #5 clk = ~clk;

    assign enA   = en & ~sel;
    assign enB   = en & sel;
    assign oSrdy = sel ? srB   : srA;
    assign oSop  = sel ? sopB  : sopA;
    assign oEop  = sel ? eopB  : eopA;
    assign oErr  = sel ? errB  : errA;
    assign oWren = sel ? wrenB : wrenA;
    assign oBusy = sel ? busyB : busyA;
    assign oData = sel ? dataB : dataA;
    assign oSeq  = sel ? seqB  : seqA;

    udp_sample_framer #(.PAYLOAD_SAMPLES(N_A)) dutA (
        .tx_clk(clk), .rstn(rstn), .enable(enA), .sample_data(sd),
        .sample_valid(sv), .sample_rdy(srA), .tx_data(dataA), .tx_sop(sopA),
        .tx_eop(eopA), .tx_err(errA), .tx_wren(wrenA), .tx_rdy(rdy),
        .seq(seqA), .busy(busyA)
    );

    udp_sample_framer #(.PAYLOAD_SAMPLES(N_B)) dutB (
        .tx_clk(clk), .rstn(rstn), .enable(enB), .sample_data(sd),
        .sample_valid(sv), .sample_rdy(srB), .tx_data(dataB), .tx_sop(sopB),
        .tx_eop(eopB), .tx_err(errB), .tx_wren(wrenB), .tx_rdy(rdy),
        .seq(seqB), .busy(busyB)
    );

    int          checks = 0;
    int          failures = 0;
    int          cycle;
    int          firstWrenCycle, eopCycle, prevEopCycle, startCycle;
    int          gapLeft;
    bit          advance;
    bit          stallPending;
    logic [7:0]  stData;
    logic        stSop, stEop;
    logic [31:0] modelSeq;
    logic [7:0]  capBytes[$];
    bit          capSop[$];
    bit          capEop[$];
    logic [31:0] accQ[$];
    logic [7:0]  expQ[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] getBytes(input int idx, input int nb);
        logic [31:0] v = 32'd0;
        for (int k = 0; k < nb; k++) begin
            if (idx + k < capBytes.size()) v = {v[23:0], capBytes[idx + k]};
            else v = {v[23:0], 8'h00};
        end
        return v;
    endfunction

    task automatic pushField(input logic [63:0] v, input int nb);
        for (int k = nb - 1; k >= 0; k--) expQ.push_back(v[8 * k +: 8]);
    endtask

    // Reference frame: header fields in wire order, then every accepted sample.
    task automatic buildExpected(input logic [31:0] s, input int n);
        int          udpLen, ipLen;
        int unsigned sum;
        logic [15:0] words[10];
        logic [15:0] csum;
        udpLen = 12 + 4 * n;
        ipLen  = udpLen + 20;
        words  = '{16'h4500, 16'(ipLen), s[15:0], 16'h4000, 16'h4011,
                   16'h0000, 16'hC0A8, 16'h0164, 16'hC0A8, 16'h0101};
        sum = 0;
        for (int k = 0; k < 10; k++) sum += int'(words[k]);
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        csum = ~sum[15:0];
        expQ.delete();
        pushField(64'hFFFFFFFFFFFF, 6);
        pushField(64'h020000000001, 6);
        pushField(64'h0800, 2);
        pushField(64'h4500, 2);
        pushField(64'(ipLen), 2);
        pushField(64'(s[15:0]), 2);
        pushField(64'h4000, 2);
        pushField(64'd64, 1);
        pushField(64'h11, 1);
        pushField(64'(csum), 2);
        pushField(64'hC0A80164, 4);
        pushField(64'hC0A80101, 4);
        pushField(64'd5000, 2);
        pushField(64'd5001, 2);
        pushField(64'(udpLen), 2);
        pushField(64'h0000, 2);
        pushField(64'(s), 4);
        foreach (accQ[k]) pushField(64'(accQ[k]), 4);
    endtask

    // One clock: drive inputs on the falling edge, then observe shortly after
    // and note which transfers the next rising edge will perform.
    task automatic applyStimulus(input logic enVal, input int rdyPct, input int svPct);
        @(negedge clk);
        if (advance) begin
            sd = $urandom;
            advance = 1'b0;
        end
        en  = enVal;
        rdy = (int'($urandom_range(99)) < rdyPct);
        sv  = (gapLeft > 0) ? 1'b0 : (int'($urandom_range(99)) < svPct);
        #1;
        cycle++;
        if (stallPending) begin
            checkOutput("stallWren", 32'(oWren), 32'd1);
            checkOutput("stallData", 32'(oData), 32'(stData));
            checkOutput("stallSop", 32'(oSop), 32'(stSop));
            checkOutput("stallEop", 32'(oEop), 32'(stEop));
        end
        if (oWren && firstWrenCycle < 0) firstWrenCycle = cycle;
        if (oWren && rdy) begin
            capBytes.push_back(oData);
            capSop.push_back(oSop);
            capEop.push_back(oEop);
            if (oEop) eopCycle = cycle;
        end
        stallPending = oWren && !rdy;
        stData = oData;
        stSop  = oSop;
        stEop  = oEop;
        if (gapLeft > 0) begin
            if (gapLeft <= 6) begin
                checkOutput("gapWren", 32'(oWren), 32'd0);
                checkOutput("gapSampleRdy", 32'(oSrdy), 32'd1);
            end
            gapLeft--;
        end
        if (sv && oSrdy) begin
            accQ.push_back(sd);
            advance = 1'b1;
        end
    endtask

    task automatic verifyFrame(input int n);
        buildExpected(modelSeq, n);
        checkOutput("frameLen", 32'(capBytes.size()), 32'(expQ.size()));
        checkOutput("samplesTaken", 32'(accQ.size()), 32'(n));
        for (int i = 0; i < capBytes.size(); i++) begin
            if (i < expQ.size())
                checkOutput($sformatf("byte%0d", i), 32'(capBytes[i]), 32'(expQ[i]));
            checkOutput($sformatf("sop%0d", i), 32'(capSop[i]), 32'(i == 0));
            checkOutput($sformatf("eop%0d", i), 32'(capEop[i]), 32'(i == expQ.size() - 1));
        end
        modelSeq = modelSeq + 32'd1;
    endtask

    task automatic runFrame(input int n, input int rdyPct, input int svPct, input bit holdEnable,
                            input int gapAt, input int resetAt, input int expectDur);
        int budget;
        bit gapDone;
        capBytes.delete();
        capSop.delete();
        capEop.delete();
        accQ.delete();
        firstWrenCycle = -1;
        eopCycle       = -1;
        stallPending   = 1'b0;
        gapLeft        = 0;
        gapDone        = 1'b0;
        applyStimulus(1'b1, rdyPct, svPct);
        startCycle = cycle;
        checkOutput("idleBusy", 32'(oBusy), 32'd0);
        checkOutput("seqOut", oSeq, modelSeq);
        budget = 0;
        while (eopCycle < 0 && budget < 20000) begin
            applyStimulus(holdEnable, rdyPct, svPct);
            budget++;
            if (!gapDone && gapAt >= 0 && capBytes.size() == gapAt) begin
                gapLeft = 10;
                gapDone = 1'b1;
            end
            if (resetAt >= 0 && capBytes.size() == resetAt) begin
                @(negedge clk);
                #2;
                rstn = 1'b0;
                #1;
                checkOutput("asyncRstWren", 32'(oWren), 32'd0);
                checkOutput("asyncRstSop", 32'(oSop), 32'd0);
                checkOutput("asyncRstEop", 32'(oEop), 32'd0);
                checkOutput("asyncRstErr", 32'(oErr), 32'd0);
                checkOutput("asyncRstSampleRdy", 32'(oSrdy), 32'd0);
                checkOutput("asyncRstBusy", 32'(oBusy), 32'd0);
                checkOutput("asyncRstData", 32'(oData), 32'd0);
                checkOutput("asyncRstSeq", oSeq, 32'd0);
                en = 1'b0;
                stallPending = 1'b0;
                gapLeft = 0;
                @(negedge clk);
                rstn = 1'b1;
                modelSeq = 32'd0;
                prevEopCycle = -1;
                return;
            end
        end
        checkOutput("frameDone", 32'(eopCycle >= 0), 32'd1);
        checkOutput("enableToWren", 32'(firstWrenCycle - startCycle), 32'd3);
        if (prevEopCycle >= 0)
            checkOutput("eopToSop", 32'(firstWrenCycle - prevEopCycle), 32'd4);
        if (expectDur >= 0)
            checkOutput("frameCycles", 32'(eopCycle - firstWrenCycle), 32'(expectDur));
        verifyFrame(n);
        prevEopCycle = eopCycle;
    endtask

    initial begin
        #900_000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rstn = 1'b0;
        en = 1'b0;
        sv = 1'b0;
        rdy = 1'b0;
        sel = 1'b0;
        sd = $urandom;
        advance = 1'b0;
        modelSeq = 32'd0;
        prevEopCycle = -1;
        cycle = 0;
        gapLeft = 0;
        stallPending = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rstWren", 32'(oWren), 32'd0);
        checkOutput("rstSop", 32'(oSop), 32'd0);
        checkOutput("rstEop", 32'(oEop), 32'd0);
        checkOutput("rstErr", 32'(oErr), 32'd0);
        checkOutput("rstSampleRdy", 32'(oSrdy), 32'd0);
        checkOutput("rstBusy", 32'(oBusy), 32'd0);
        checkOutput("rstData", 32'(oData), 32'd0);
        checkOutput("rstSeq", oSeq, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        $display("[TB] default frame, no stalls");
        runFrame(N_A, 100, 100, 1'b1, -1, -1, 46 + 4 * N_A);
        checkOutput("etherType", getBytes(12, 2), 32'h0800);
        checkOutput("ipLen", getBytes(16, 2), 32'h0420);
        checkOutput("ipCsum0", getBytes(24, 2), 32'hB317);
        checkOutput("udpLen", getBytes(38, 2), 32'h040C);
        checkOutput("seqField0", getBytes(42, 4), 32'h00000000);

        $display("[TB] second frame, enable dropped, starved source");
        runFrame(N_A, 100, 100, 1'b0, 300, -1, -1);
        checkOutput("ident1", getBytes(18, 2), 32'h0001);
        checkOutput("ipCsum1", getBytes(24, 2), 32'hB316);
        checkOutput("seqField1", getBytes(42, 4), 32'h00000001);

        $display("[TB] MAC back-pressure and bursty source");
        runFrame(N_A, 50, 80, 1'b0, -1, -1, -1);

        $display("[TB] reset mid-payload");
        runFrame(N_A, 70, 90, 1'b0, -1, 500, -1);
        runFrame(N_A, 100, 100, 1'b0, -1, -1, 46 + 4 * N_A);
        checkOutput("seqFieldAfterRst", getBytes(42, 4), 32'h00000000);
        checkOutput("ipCsumAfterRst", getBytes(24, 2), 32'hB317);

        $display("[TB] single-sample frames and sequence wrap");
        @(negedge clk);
        sel = 1'b1;
        en = 1'b0;
        modelSeq = 32'd0;
        prevEopCycle = -1;
        runFrame(N_B, 100, 100, 1'b0, -1, -1, 46 + 4 * N_B);
        @(negedge clk);
        force dutB.seq_q = 32'hFFFFFFFF;
        #1;
        release dutB.seq_q;
        modelSeq = 32'hFFFFFFFF;
        prevEopCycle = -1;
        runFrame(N_B, 60, 70, 1'b0, -1, -1, -1);
        checkOutput("seqFieldMax", getBytes(42, 4), 32'hFFFFFFFF);
        runFrame(N_B, 100, 100, 1'b0, -1, -1, 46 + 4 * N_B);
        checkOutput("seqFieldWrap", getBytes(42, 4), 32'h00000000);
        checkOutput("errTied", 32'(oErr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
